// File: rtl/rotate_engine.sv
// rotate_engine: bit-serial rotator, one position per clock; captures a request,
// rotates it in place and holds the result until the consumer takes it.
//
// state | meaning
// IDLE  | ready to accept a request
// BUSY  | rotating, cnt positions still to go
// DONE  | result on out_data, waiting for out_ready
module rotate_engine #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [AMT_W-1:0] in_amt,
   input  logic             in_dir,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [AMT_W-1:0] cnt;
   logic [WIDTH-1:0] work;
   logic [WIDTH-1:0] work_rot;
   logic             dir;

   // dir=1 rotates left (MSB wraps to LSB), dir=0 rotates right
   always_comb begin
      work_rot = work;
      if (dir) begin
         work_rot = {work[WIDTH-2:0], work[WIDTH-1]};
      end else begin
         work_rot = {work[0], work[WIDTH-1:1]};
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (in_valid) begin
               state_nx = (in_amt == '0) ? DONE : BUSY;
            end
         end
         BUSY: begin
            if (cnt == AMT_W'(1)) begin
               state_nx = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         work  <= '0;
         dir   <= 1'b0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  work <= in_data;
                  cnt  <= in_amt;
                  dir  <= in_dir;
               end
            end
            BUSY: begin
               work <= work_rot;
               cnt  <= cnt - AMT_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign out_data  = work;

endmodule

// File: tb/tb_rotate_engine.sv
// Bench for rotate_engine: 8-bit and 16-bit instances, table-driven requests
// with a result scoreboard, plus reset-abort and reset-release sequences.
module tb_rotate_engine;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        a_in_valid, a_in_ready, a_in_dir, a_out_valid, a_out_ready, a_busy;
   logic [7:0]  a_in_data, a_out_data;
   logic [2:0]  a_in_amt;
   logic        b_in_valid, b_in_ready, b_in_dir, b_out_valid, b_out_ready, b_busy;
   logic [15:0] b_in_data, b_out_data;
   logic [3:0]  b_in_amt;

   int checks   = 0;
   int failures = 0;
   logic [15:0] q8[$];
   logic [15:0] q16[$];

   rotate_engine #(.WIDTH(8), .AMT_W(3)) dut8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
      .in_amt(a_in_amt), .in_dir(a_in_dir),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
      .busy(a_busy)
   );

   rotate_engine #(.WIDTH(16), .AMT_W(4)) dut16 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .in_amt(b_in_amt), .in_dir(b_in_dir),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .busy(b_busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   function automatic logic irdy(input bit s);
      return s ? b_in_ready : a_in_ready;
   endfunction
   function automatic logic ovalid(input bit s);
      return s ? b_out_valid : a_out_valid;
   endfunction
   function automatic logic bsy(input bit s);
      return s ? b_busy : a_busy;
   endfunction
   function automatic logic [15:0] odata(input bit s);
      return s ? b_out_data : {8'h00, a_out_data};
   endfunction

   task automatic set_in(input bit s, input logic v, input logic [15:0] d,
                         input logic [3:0] a, input logic dr);
      if (s) begin
         b_in_valid = v; b_in_data = d; b_in_amt = a; b_in_dir = dr;
      end else begin
         a_in_valid = v; a_in_data = d[7:0]; a_in_amt = a[2:0]; a_in_dir = dr;
      end
   endtask

   task automatic set_ordy(input bit s, input logic v);
      if (s) b_out_ready = v;
      else   a_out_ready = v;
   endtask

   // Scoreboard: one pop per completed transfer (valid & ready seen mid-cycle)
   always @(negedge clk) begin
      if (rst_n && a_out_valid && a_out_ready) begin
         if (q8.size() == 0) begin
            checks++; failures++;
            $display("FAIL sb8_unexpected actual=0x%0h required=none", a_out_data);
         end else begin
            check("sb8_data", 32'(a_out_data), 32'(q8.pop_front()));
         end
      end
      if (rst_n && b_out_valid && b_out_ready) begin
         if (q16.size() == 0) begin
            checks++; failures++;
            $display("FAIL sb16_unexpected actual=0x%0h required=none", b_out_data);
         end else begin
            check("sb16_data", 32'(b_out_data), 32'(q16.pop_front()));
         end
      end
   end

   task automatic send(input string tag, input bit s, input logic [15:0] d,
                       input logic [3:0] a, input logic dr, input logic [15:0] e,
                       input int hold);
      int n;
      n = 0;
      while (!irdy(s) && n < 50) begin
         @(posedge clk); #1; n++;
      end
      check({tag, "_ready"}, 32'(irdy(s)), 32'd1);
      set_in(s, 1'b1, d, a, dr);
      set_ordy(s, hold == 0);
      if (s) q16.push_back(e);
      else   q8.push_back(e);
      @(posedge clk); #1;
      set_in(s, 1'b0, 16'h0, 4'h0, 1'b0);
      for (int k = 0; k < int'(a); k++) begin
         check({tag, "_early_valid"}, 32'(ovalid(s)), 32'd0);
         check({tag, "_busy"}, 32'(bsy(s)), 32'd1);
         @(posedge clk); #1;
      end
      check({tag, "_done_valid"}, 32'(ovalid(s)), 32'd1);
      check({tag, "_done_busy"}, 32'(bsy(s)), 32'd1);
      check({tag, "_done_rdy"}, 32'(irdy(s)), 32'd0);
      check({tag, "_done_data"}, 32'(odata(s)), 32'(e));
      for (int h = 0; h < hold; h++) begin
         set_in(s, 1'($urandom), 16'($urandom), 4'($urandom), 1'($urandom));
         @(posedge clk); #1;
         check({tag, "_hold_data"}, 32'(odata(s)), 32'(e));
         check({tag, "_hold_valid"}, 32'(ovalid(s)), 32'd1);
         check({tag, "_hold_rdy"}, 32'(irdy(s)), 32'd0);
      end
      // request offered in the completing cycle must not be taken
      set_in(s, 1'b1, 16'($urandom), 4'($urandom), 1'b0);
      set_ordy(s, 1'b1);
      @(posedge clk); #1;
      check({tag, "_end_rdy"}, 32'(irdy(s)), 32'd1);
      check({tag, "_end_valid"}, 32'(ovalid(s)), 32'd0);
      check({tag, "_end_busy"}, 32'(bsy(s)), 32'd0);
      set_in(s, 1'b0, 16'h0, 4'h0, 1'b0);
      set_ordy(s, 1'b0);
   endtask

   typedef struct {
      bit          sel;
      logic [15:0] d;
      logic [3:0]  a;
      logic        dr;
      logic [15:0] e;
      int          hold;
   } vec_t;

   vec_t vt[13];

   initial begin
      vt[0]  = '{1'b0, 16'h00B1, 4'd1,  1'b0, 16'h00D8, 0};
      vt[1]  = '{1'b0, 16'h0081, 4'd3,  1'b1, 16'h000C, 5};
      vt[2]  = '{1'b0, 16'h005A, 4'd0,  1'b0, 16'h005A, 2};
      vt[3]  = '{1'b0, 16'h0001, 4'd7,  1'b0, 16'h0002, 0};
      vt[4]  = '{1'b0, 16'h0080, 4'd1,  1'b1, 16'h0001, 1};
      vt[5]  = '{1'b0, 16'h00F0, 4'd4,  1'b0, 16'h000F, 0};
      vt[6]  = '{1'b0, 16'h0096, 4'd2,  1'b1, 16'h005A, 0};
      vt[7]  = '{1'b0, 16'h003C, 4'd5,  1'b0, 16'h00E1, 3};
      vt[8]  = '{1'b0, 16'h00A5, 4'd6,  1'b1, 16'h0069, 0};
      vt[9]  = '{1'b1, 16'h1234, 4'd4,  1'b0, 16'h4123, 0};
      vt[10] = '{1'b1, 16'h1234, 4'd15, 1'b1, 16'h091A, 2};
      vt[11] = '{1'b1, 16'h8001, 4'd1,  1'b1, 16'h0003, 0};
      vt[12] = '{1'b1, 16'hBEEF, 4'd0,  1'b1, 16'hBEEF, 1};

      rst_n = 1'b0;
      set_in(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
      set_in(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
      set_ordy(1'b0, 1'b0);
      set_ordy(1'b1, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check("rst8_rdy", 32'(a_in_ready), 32'd1);
      check("rst8_valid", 32'(a_out_valid), 32'd0);
      check("rst8_busy", 32'(a_busy), 32'd0);
      check("rst8_data", 32'(a_out_data), 32'd0);
      check("rst16_rdy", 32'(b_in_ready), 32'd1);
      check("rst16_data", 32'(b_out_data), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 13; i++) begin
         send($sformatf("v%0d", i), vt[i].sel, vt[i].d, vt[i].a, vt[i].dr,
              vt[i].e, vt[i].hold);
      end

      // Abort an amt=7 request mid-rotation; nothing may reach the scoreboard
      set_in(1'b0, 1'b1, 16'h0001, 4'd7, 1'b0);
      set_ordy(1'b0, 1'b1);
      @(posedge clk); #1;
      set_in(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check("abort_busy_pre", 32'(a_busy), 32'd1);
      rst_n = 1'b0;
      set_in(1'b0, 1'b1, 16'h00F0, 4'd4, 1'b0);
      @(posedge clk); #1;
      check("abort_rdy", 32'(a_in_ready), 32'd1);
      check("abort_valid", 32'(a_out_valid), 32'd0);
      check("abort_busy", 32'(a_busy), 32'd0);
      check("abort_data", 32'(a_out_data), 32'd0);
      @(posedge clk); #1;
      check("inrst_noaccept_rdy", 32'(a_in_ready), 32'd1);
      check("inrst_noaccept_busy", 32'(a_busy), 32'd0);
      set_ordy(1'b0, 1'b0);
      rst_n = 1'b1;
      send("rel", 1'b0, 16'h00F0, 4'd4, 1'b0, 16'h000F, 0);

      repeat (10) @(posedge clk);
      #1;
      check("sb8_drain", 32'(q8.size()), 32'd0);
      check("sb16_drain", 32'(q16.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
